// File: rtl/hwpe_stream_fence_buffered.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// hwpe_stream_fence_buffered
//
// Multi-stream synchronising fence. Every input stream owns a DEPTH-entry FIFO.
// The streams selected by the participation mask are released to their
// consumers as one aligned group: one beat from every enabled stream at once.
// Each consumer may accept its beat in a different cycle; the heads are only
// popped when the last enabled consumer has taken its beat. Streams outside
// the mask behave as plain FIFOs.
//
// Optional feature macro: HWPE_STREAM_FENCE_BUFFERED_CNT_EN
//   defined   -> 16-bit wrapping counter of completed groups on fence_cnt_o
//   undefined -> fence_cnt_o is tied to zero
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         synchronous active-low reset
//   clear_i        synchronous soft clear, same effect as reset
//   test_mode_i    unused
//   enable_mask_i  bit i = 1 puts stream i in the fence group
//   push_valid_i / push_ready_o / push_data_i / push_strb_i
//                  input streams, one lane per stream
//   pop_valid_o / pop_ready_i / pop_data_o / pop_strb_o
//                  output streams, one lane per stream
//   fence_cnt_o    number of completed aligned groups
// ----------------------------------------------------------------------------
module hwpe_stream_fence_buffered #(
    parameter int unsigned NB_STREAMS = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     clear_i,
    input  logic                                     test_mode_i,
    input  logic [NB_STREAMS-1:0]                    enable_mask_i,
    input  logic [NB_STREAMS-1:0]                    push_valid_i,
    output logic [NB_STREAMS-1:0]                    push_ready_o,
    input  logic [NB_STREAMS-1:0][DATA_WIDTH-1:0]    push_data_i,
    input  logic [NB_STREAMS-1:0][DATA_WIDTH/8-1:0]  push_strb_i,
    output logic [NB_STREAMS-1:0]                    pop_valid_o,
    input  logic [NB_STREAMS-1:0]                    pop_ready_i,
    output logic [NB_STREAMS-1:0][DATA_WIDTH-1:0]    pop_data_o,
    output logic [NB_STREAMS-1:0][DATA_WIDTH/8-1:0]  pop_strb_o,
    output logic [15:0]                              fence_cnt_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PTR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 1);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [NB_STREAMS-1:0] mask_q;
    logic [NB_STREAMS-1:0] mask_d;
    logic [NB_STREAMS-1:0] taken_q;
    logic [NB_STREAMS-1:0] taken_d;

    logic [DATA_WIDTH-1:0] dataMem_q [NB_STREAMS][DEPTH];
    logic [STRB_WIDTH-1:0] strbMem_q [NB_STREAMS][DEPTH];

    logic [PTR_WIDTH-1:0] rdPtr_q [NB_STREAMS];
    logic [PTR_WIDTH-1:0] rdPtr_d [NB_STREAMS];
    logic [PTR_WIDTH-1:0] wrPtr_q [NB_STREAMS];
    logic [PTR_WIDTH-1:0] wrPtr_d [NB_STREAMS];
    logic [CNT_WIDTH-1:0] count_q [NB_STREAMS];
    logic [CNT_WIDTH-1:0] count_d [NB_STREAMS];

    logic [NB_STREAMS-1:0] notEmpty;
    logic [NB_STREAMS-1:0] pushReady;
    logic [NB_STREAMS-1:0] pushHs;
    logic [NB_STREAMS-1:0] popValid;
    logic [NB_STREAMS-1:0] popHs;
    logic [NB_STREAMS-1:0] popFifo;
    logic                  groupReady;
    logic                  groupDone;
    logic                  maskReload;

    logic unusedTestMode;
    assign unusedTestMode = test_mode_i;

    // Per-FIFO occupancy flags. Ready looks only at the stored count, so a
    // full FIFO refuses a push even in a cycle where it also pops, and the
    // producer's ready never depends on its own valid.
    always_comb begin
        notEmpty  = '0;
        pushReady = '0;
        for (int i = 0; i < NB_STREAMS; i++) begin
            notEmpty[i]  = (count_q[i] != '0);
            pushReady[i] = (count_q[i] != FULL_CNT);
        end
    end

    // Fence control. An enabled stream offers its head only while the whole
    // group is present and it has not already handed over its beat. The group
    // completes when every enabled consumer has either taken its beat earlier
    // or takes it now; only then do the enabled heads leave their FIFOs, which
    // keeps the head stable for the whole pending group. An empty mask means
    // there is no group, so nothing ever completes. The mask is only swapped
    // at a clean boundary: nothing taken, nothing being taken, no completion.
    always_comb begin
        groupReady = &(notEmpty | ~mask_q);
        popValid   = '0;
        for (int i = 0; i < NB_STREAMS; i++) begin
            popValid[i] = mask_q[i] ? (groupReady & ~taken_q[i]) : notEmpty[i];
        end
        popHs      = popValid & pop_ready_i;
        pushHs     = push_valid_i & pushReady;
        groupDone  = (mask_q != '0) && (&(taken_q | popHs | ~mask_q));
        popFifo    = (popHs & ~mask_q) | (groupDone ? mask_q : '0);
        taken_d    = groupDone ? '0 : (mask_q & (taken_q | popHs));
        maskReload = (taken_q == '0) && ((popHs & mask_q) == '0) && !groupDone;
        mask_d     = maskReload ? enable_mask_i : mask_q;
    end

    // Pointer and count bookkeeping for every FIFO. Pointers wrap explicitly
    // at DEPTH-1 so non-power-of-two depths work; a simultaneous push and pop
    // leaves the count unchanged.
    always_comb begin
        for (int i = 0; i < NB_STREAMS; i++) begin
            rdPtr_d[i] = rdPtr_q[i];
            wrPtr_d[i] = wrPtr_q[i];
            count_d[i] = count_q[i];
            if (popFifo[i]) begin
                rdPtr_d[i] = (rdPtr_q[i] == LAST_PTR) ? '0 : rdPtr_q[i] + PTR_WIDTH'(1);
            end
            if (pushHs[i]) begin
                wrPtr_d[i] = (wrPtr_q[i] == LAST_PTR) ? '0 : wrPtr_q[i] + PTR_WIDTH'(1);
            end
            case ({pushHs[i], popFifo[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_WIDTH'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_WIDTH'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    // Control state. Clear is folded into reset so it wins over every push,
    // pop and mask reload in the same cycle; both reload the mask directly.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            mask_q  <= enable_mask_i;
            taken_q <= '0;
            for (int i = 0; i < NB_STREAMS; i++) begin
                rdPtr_q[i] <= '0;
                wrPtr_q[i] <= '0;
                count_q[i] <= '0;
            end
        end else begin
            mask_q  <= mask_d;
            taken_q <= taken_d;
            for (int i = 0; i < NB_STREAMS; i++) begin
                rdPtr_q[i] <= rdPtr_d[i];
                wrPtr_q[i] <= wrPtr_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    // FIFO storage. It is zeroed on reset and clear so the pop data lanes
    // read as zero until the first beat arrives.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            for (int i = 0; i < NB_STREAMS; i++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    dataMem_q[i][d] <= '0;
                    strbMem_q[i][d] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NB_STREAMS; i++) begin
                if (pushHs[i]) begin
                    dataMem_q[i][wrPtr_q[i]] <= push_data_i[i];
                    strbMem_q[i][wrPtr_q[i]] <= push_strb_i[i];
                end
            end
        end
    end

    // Output lanes always show the head entry of each FIFO.
    always_comb begin
        for (int i = 0; i < NB_STREAMS; i++) begin
            pop_data_o[i] = dataMem_q[i][rdPtr_q[i]];
            pop_strb_o[i] = strbMem_q[i][rdPtr_q[i]];
        end
    end

    assign pop_valid_o  = popValid;
    assign push_ready_o = pushReady;

`ifdef HWPE_STREAM_FENCE_BUFFERED_CNT_EN
    logic [15:0] fenceCnt_q;
    logic [15:0] fenceCnt_d;

    // Completed-group counter, free-running and wrapping at 16 bits.
    always_comb begin
        fenceCnt_d = groupDone ? fenceCnt_q + 16'd1 : fenceCnt_q;
    end

    // Counter register, cleared together with the fence state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            fenceCnt_q <= '0;
        end else begin
            fenceCnt_q <= fenceCnt_d;
        end
    end

    assign fence_cnt_o = fenceCnt_q;
`else
    assign fence_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_hwpe_stream_fence_buffered.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_hwpe_stream_fence_buffered
//
// Bench for the buffered stream fence with two streams of 32 bits and two
// FIFO entries per stream. A table of hand-derived cycle vectors walks through
// alignment, staggered consumers, full FIFOs, masked streams, a mid-group mask
// change and a mid-group clear. A queue-based reference model then follows
// randomized traffic, and with HWPE_STREAM_FENCE_BUFFERED_CNT_EN defined the
// group counter is driven through its wrap.
// ----------------------------------------------------------------------------
module tb_hwpe_stream_fence_buffered;

    localparam int NB    = 2;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 2;

    logic                   clk = 1'b0;
    logic                   rstN;
    logic                   clear;
    logic                   testMode;
    logic [NB-1:0]          enableMask;
    logic [NB-1:0]          pushValid;
    logic [NB-1:0]          pushReady;
    logic [NB-1:0][DW-1:0]  pushData;
    logic [NB-1:0][SW-1:0]  pushStrb;
    logic [NB-1:0]          popValid;
    logic [NB-1:0]          popReady;
    logic [NB-1:0][DW-1:0]  popData;
    logic [NB-1:0][SW-1:0]  popStrb;
    logic [15:0]            fenceCnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        clr;
        logic [1:0]  mask;
        logic [1:0]  pv;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic [1:0]  pr;
        logic [1:0]  eReady;
        logic [1:0]  eValid;
        logic        cd;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [15:0] eCnt;
    } vec_t;

    vec_t tbl[$];

    logic [1:0]  mMask;
    logic [1:0]  mTaken;
    logic [15:0] mCnt;
    logic [35:0] modelQ [NB][$];

    hwpe_stream_fence_buffered #(
        .NB_STREAMS (NB),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .clear_i       (clear),
        .test_mode_i   (testMode),
        .enable_mask_i (enableMask),
        .push_valid_i  (pushValid),
        .push_ready_o  (pushReady),
        .push_data_i   (pushData),
        .push_strb_i   (pushStrb),
        .pop_valid_o   (popValid),
        .pop_ready_i   (popReady),
        .pop_data_o    (popData),
        .pop_strb_o    (popStrb),
        .fence_cnt_o   (fenceCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // The counter only exists with the feature macro; otherwise it reads 0.
    function automatic logic [15:0] cntView(input logic [15:0] n);
`ifdef HWPE_STREAM_FENCE_BUFFERED_CNT_EN
        return n;
`else
        return n & 16'h0000;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        clear       = v.clr;
        enableMask  = v.mask;
        pushValid   = v.pv;
        pushData[0] = v.d0;
        pushData[1] = v.d1;
        pushStrb[0] = v.s0;
        pushStrb[1] = v.s1;
        popReady    = v.pr;
    endtask

    task automatic addRow(input logic clr, input logic [1:0] mask, input logic [1:0] pv,
                          input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] pr,
                          input logic [1:0] eReady, input logic [1:0] eValid, input logic cd,
                          input logic [31:0] e0, input logic [31:0] e1, input logic [15:0] eCnt);
        vec_t v;
        v.clr = clr; v.mask = mask; v.pv = pv; v.d0 = d0; v.d1 = d1;
        v.s0 = d0[3:0]; v.s1 = d1[3:0]; v.pr = pr;
        v.eReady = eReady; v.eValid = eValid; v.cd = cd;
        v.e0 = e0; v.e1 = e1; v.eCnt = eCnt;
        tbl.push_back(v);
    endtask

    // One cycle against the reference model: expected outputs come from the
    // queues and the group rules, then the model advances with the inputs.
    task automatic modelCycle(input string tag);
        logic [1:0] expReady;
        logic [1:0] expValid;
        logic [1:0] hs;
        bit         allFilled;
        bit         done;
        bit         boundary;
        logic [35:0] head;
        for (int i = 0; i < NB; i++) expReady[i] = (modelQ[i].size() < DEPTH);
        allFilled = 1'b1;
        for (int i = 0; i < NB; i++) if (mMask[i] && modelQ[i].size() == 0) allFilled = 1'b0;
        for (int i = 0; i < NB; i++)
            expValid[i] = mMask[i] ? (allFilled && !mTaken[i]) : (modelQ[i].size() != 0);
        #1;
        checkOutput($sformatf("%s push_ready", tag), 64'(pushReady), 64'(expReady));
        checkOutput($sformatf("%s pop_valid", tag), 64'(popValid), 64'(expValid));
        checkOutput($sformatf("%s fence_cnt", tag), 64'(fenceCnt), 64'(cntView(mCnt)));
        for (int i = 0; i < NB; i++) begin
            if (expValid[i] || (mMask[i] && mTaken[i])) begin
                head = modelQ[i][0];
                checkOutput($sformatf("%s pop_data%0d", tag, i), 64'(popData[i]), 64'(head[31:0]));
                checkOutput($sformatf("%s pop_strb%0d", tag, i), 64'(popStrb[i]), 64'(head[35:32]));
            end
        end
        if (clear) begin
            for (int i = 0; i < NB; i++) modelQ[i].delete();
            mTaken = '0;
            mCnt   = '0;
            mMask  = enableMask;
        end else begin
            hs   = expValid & popReady;
            done = (mMask != 2'b00);
            for (int i = 0; i < NB; i++) if (mMask[i] && !(mTaken[i] || hs[i])) done = 1'b0;
            boundary = (mTaken == 2'b00) && ((hs & mMask) == 2'b00) && !done;
            for (int i = 0; i < NB; i++) begin
                if (mMask[i] ? done : hs[i]) void'(modelQ[i].pop_front());
                if (pushValid[i] && expReady[i]) modelQ[i].push_back({pushStrb[i], pushData[i]});
            end
            mTaken = done ? 2'b00 : (mTaken | (hs & mMask));
            if (done) mCnt = mCnt + 16'd1;
            if (boundary) mMask = enableMask;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randomInputs(input bit allowClear);
        clear = allowClear && ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 19) == 0) enableMask = 2'($urandom_range(0, 3));
        for (int i = 0; i < NB; i++) begin
            pushValid[i] = $urandom_range(0, 1) == 1;
            pushData[i]  = $urandom;
            pushStrb[i]  = 4'($urandom_range(0, 15));
            popReady[i]  = $urandom_range(0, 9) < 7;
        end
    endtask

    initial begin
        vec_t v;
        int   guard;

        rstN = 1'b0; clear = 1'b0; testMode = 1'b0; enableMask = 2'b11;
        pushValid = '0; pushData = '0; pushStrb = '0; popReady = '0;

        // basic alignment
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, 1, 0, 0, 0);
        addRow(0, 2'b11, 2'b01, 32'hA000_0001, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0);
        addRow(0, 2'b11, 2'b10, 0, 32'hB000_0002, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 2'b11, 0, 32'hA000_0001, 32'hB000_0002, 0);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 1);
        // staggered ready, head held while the group is pending
        addRow(0, 2'b11, 2'b11, 32'hA001_0003, 32'hB001_0004, 2'b00, 2'b11, 2'b00, 0, 0, 0, 1);
        addRow(0, 2'b11, 2'b11, 32'hA002_0005, 32'hB002_0006, 2'b01, 2'b11, 2'b11, 0, 32'hA001_0003, 32'hB001_0004, 1);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 2'b10, 1, 32'hA001_0003, 32'hB001_0004, 1);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 2'b10, 1, 32'hA001_0003, 32'hB001_0004, 1);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b10, 2'b00, 2'b10, 1, 32'hA001_0003, 32'hB001_0004, 1);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b00, 2'b11, 2'b11, 0, 32'hA002_0005, 32'hB002_0006, 2);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 2'b11, 0, 32'hA002_0005, 32'hB002_0006, 2);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 3);
        // full FIFO on stream 0
        addRow(0, 2'b11, 2'b01, 32'hC000_0007, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 3);
        addRow(0, 2'b11, 2'b01, 32'hC001_0008, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 3);
        addRow(0, 2'b11, 2'b01, 32'hC002_0009, 0, 2'b11, 2'b10, 2'b00, 0, 0, 0, 3);
        addRow(0, 2'b11, 2'b11, 32'hC002_0009, 32'hD000_000A, 2'b11, 2'b10, 2'b00, 0, 0, 0, 3);
        addRow(0, 2'b11, 2'b01, 32'hC002_0009, 0, 2'b11, 2'b10, 2'b11, 0, 32'hC000_0007, 32'hD000_000A, 3);
        addRow(0, 2'b11, 2'b01, 32'hC002_0009, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 4);
        addRow(0, 2'b11, 2'b10, 0, 32'hD001_000B, 2'b11, 2'b10, 2'b00, 0, 0, 0, 4);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b11, 2'b10, 2'b11, 0, 32'hC001_0008, 32'hD001_000B, 4);
        addRow(0, 2'b11, 2'b10, 0, 32'hD002_000C, 2'b11, 2'b11, 2'b00, 0, 0, 0, 5);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 2'b11, 0, 32'hC002_0009, 32'hD002_000C, 5);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 6);
        // stream 1 masked out: plain FIFO with one cycle latency
        addRow(0, 2'b01, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 6);
        addRow(0, 2'b01, 2'b10, 0, 32'hE000_000D, 2'b11, 2'b11, 2'b00, 0, 0, 0, 6);
        addRow(0, 2'b01, 2'b10, 0, 32'hE001_000E, 2'b11, 2'b11, 2'b10, 0, 0, 32'hE000_000D, 6);
        addRow(0, 2'b01, 2'b10, 0, 32'hE002_000F, 2'b11, 2'b11, 2'b10, 0, 0, 32'hE001_000E, 6);
        addRow(0, 2'b01, 2'b10, 0, 32'hE003_0001, 2'b11, 2'b11, 2'b10, 0, 0, 32'hE002_000F, 6);
        addRow(0, 2'b01, 2'b00, 0, 0, 2'b11, 2'b11, 2'b10, 0, 0, 32'hE003_0001, 6);
        addRow(0, 2'b01, 2'b01, 32'hF000_0002, 0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 6);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b00, 2'b11, 2'b01, 0, 32'hF000_0002, 0, 6);
        // mask change while taken = 01 waits for the group to finish
        addRow(0, 2'b11, 2'b10, 0, 32'h6000_0003, 2'b00, 2'b11, 2'b00, 0, 0, 0, 6);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b01, 2'b11, 2'b11, 0, 32'hF000_0002, 32'h6000_0003, 6);
        addRow(0, 2'b10, 2'b00, 0, 0, 2'b00, 2'b11, 2'b10, 1, 32'hF000_0002, 32'h6000_0003, 6);
        addRow(0, 2'b10, 2'b00, 0, 0, 2'b00, 2'b11, 2'b10, 1, 32'hF000_0002, 32'h6000_0003, 6);
        addRow(0, 2'b10, 2'b00, 0, 0, 2'b10, 2'b11, 2'b10, 1, 32'hF000_0002, 32'h6000_0003, 6);
        addRow(0, 2'b10, 2'b01, 32'h7000_0004, 0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 7);
        addRow(0, 2'b10, 2'b00, 0, 0, 2'b00, 2'b11, 2'b01, 0, 32'h7000_0004, 0, 7);
        addRow(0, 2'b10, 2'b00, 0, 0, 2'b01, 2'b11, 2'b01, 0, 32'h7000_0004, 0, 7);
        addRow(0, 2'b10, 2'b00, 0, 0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 7);
        // clear with both FIFOs full and taken = 10
        addRow(0, 2'b11, 2'b11, 32'h8000_0005, 32'h9000_0006, 2'b00, 2'b11, 2'b00, 0, 0, 0, 7);
        addRow(0, 2'b11, 2'b11, 32'h8001_0007, 32'h9001_0008, 2'b10, 2'b11, 2'b11, 0, 32'h8000_0005, 32'h9000_0006, 7);
        addRow(1, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 0, 32'h8000_0005, 0, 7);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b00, 2'b11, 2'b00, 1, 0, 0, 0);
        addRow(0, 2'b11, 2'b11, 32'h1000_0009, 32'h2000_000A, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 2'b11, 0, 32'h1000_0009, 32'h2000_000A, 0);
        addRow(0, 2'b11, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;

        $display("[TB] directed vectors: %0d rows", tbl.size());
        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            applyStimulus(v);
            #1;
            checkOutput($sformatf("row%0d push_ready", r), 64'(pushReady), 64'(v.eReady));
            checkOutput($sformatf("row%0d pop_valid", r), 64'(popValid), 64'(v.eValid));
            checkOutput($sformatf("row%0d fence_cnt", r), 64'(fenceCnt), 64'(cntView(v.eCnt)));
            if (v.eValid[0] || v.cd) begin
                checkOutput($sformatf("row%0d pop_data0", r), 64'(popData[0]), 64'(v.e0));
                checkOutput($sformatf("row%0d pop_strb0", r), 64'(popStrb[0]), 64'(v.e0[3:0]));
            end
            if (v.eValid[1] || v.cd) begin
                checkOutput($sformatf("row%0d pop_data1", r), 64'(popData[1]), 64'(v.e1));
                checkOutput($sformatf("row%0d pop_strb1", r), 64'(popStrb[1]), 64'(v.e1[3:0]));
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] randomized traffic against reference model");
        clear = 1'b1; enableMask = 2'b11; pushValid = '0; popReady = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NB; i++) modelQ[i].delete();
        mMask = 2'b11; mTaken = '0; mCnt = '0;
        for (int c = 0; c < 3000; c++) begin
            randomInputs(1'b1);
            modelCycle($sformatf("rand%0d", c));
        end

`ifdef HWPE_STREAM_FENCE_BUFFERED_CNT_EN
        $display("[TB] counter wrap");
        clear = 1'b1; enableMask = 2'b11; pushValid = '0; popReady = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NB; i++) modelQ[i].delete();
        mMask = 2'b11; mTaken = '0; mCnt = '0;
        clear = 1'b0; pushValid = 2'b11; popReady = 2'b11;
        guard = 0;
        while (mCnt != 16'hFFFF && guard < 70000) begin
            pushData[0] = $urandom; pushData[1] = $urandom;
            modelCycle("wrap");
            guard++;
        end
        checkOutput("wrap preset", 64'(fenceCnt), 64'(16'hFFFF));
        guard = 0;
        while (mCnt != 16'h0000 && guard < 10) begin
            modelCycle("wrap");
            guard++;
        end
        checkOutput("wrap to zero", 64'(fenceCnt), 64'(16'h0000));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
